// File: rtl/if_id_skid.sv
// IF->ID pipeline register with a two-entry skid buffer and a registered in_ready_o.
// Flush empties the stage; a saturating counter tracks cycles where ID was starved.
module if_id_skid #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(32'h00000013),
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic [DATA_WIDTH-1:0] inst_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    input  logic                  cnt_clr_i,
    output logic [CNT_WIDTH-1:0]  bubble_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] main_addr_q, main_addr_d;
    logic [DATA_WIDTH-1:0] main_inst_q, main_inst_d;
    logic [ADDR_WIDTH-1:0] skid_addr_q, skid_addr_d;
    logic [DATA_WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic                  in_ready_q, in_ready_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic in_fire;
    logic out_fire;

    assign out_valid_o  = (state_q != EMPTY);
    assign in_ready_o   = in_ready_q;
    assign inst_addr_o  = main_addr_q;
    assign inst_o       = main_inst_q;
    assign bubble_cnt_o = cnt_q;

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = out_valid_o & out_ready_i;

    // The main entry is rewritten to NOP/0 whenever the stage empties, so the
    // invalid-output values come straight from registers.
    always_comb begin
        state_d     = state_q;
        main_addr_d = main_addr_q;
        main_inst_d = main_inst_q;
        skid_addr_d = skid_addr_q;
        skid_inst_d = skid_inst_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_addr_d = inst_addr_i;
                    main_inst_d = inst_i;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_addr_d = inst_addr_i;
                    main_inst_d = inst_i;
                end else if (in_fire) begin
                    skid_addr_d = inst_addr_i;
                    skid_inst_d = inst_i;
                    state_d     = FULL;
                end else if (out_fire) begin
                    main_addr_d = '0;
                    main_inst_d = NOP_INST;
                    state_d     = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_addr_d = skid_addr_q;
                    main_inst_d = skid_inst_q;
                    state_d     = ONE;
                end
            end
            default: begin
                main_addr_d = '0;
                main_inst_d = NOP_INST;
                state_d     = EMPTY;
            end
        endcase

        if (flush_i) begin
            main_addr_d = '0;
            main_inst_d = NOP_INST;
            state_d     = EMPTY;
        end
    end

    // Ready is derived from the next state so it leaves a flop with no path from out_ready_i.
    assign in_ready_d = (state_d != FULL);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (out_ready_i && !out_valid_o && !flush_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            main_addr_q <= '0;
            main_inst_q <= NOP_INST;
            skid_addr_q <= '0;
            skid_inst_q <= NOP_INST;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_addr_q <= main_addr_d;
            main_inst_q <= main_inst_d;
            skid_addr_q <= skid_addr_d;
            skid_inst_q <= skid_inst_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: a queue model of the stage (capacity two) checked every cycle,
// plus directed scenarios with literal expectations and a randomized run.
module tb_if_id_skid;

    localparam int CW = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   inst_addr;
    logic [31:0]   inst;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   addr_o;
    logic [31:0]   inst_o;
    logic          cnt_clr;
    logic [CW-1:0] bubble_cnt;

    if_id_skid #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NOP_INST  (NOP),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .inst_addr_i (inst_addr),
        .inst_i      (inst),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .inst_addr_o (addr_o),
        .inst_o      (inst_o),
        .cnt_clr_i   (cnt_clr),
        .bubble_cnt_o(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   mcnt;
    bit   chk_en;
    int   n_total;
    int   n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Advance one clock edge, updating the model from the inputs the DUT sampled.
    task automatic tick();
        bit rdy, ov, inf, of;
        @(posedge clk);
        rdy = (mq.size() < 2);
        ov  = (mq.size() > 0);
        inf = in_valid && rdy;
        of  = ov && out_ready;
        if (cnt_clr) mcnt = 0;
        else if (out_ready && !ov && !flush && mcnt < (1 << CW) - 1) mcnt++;
        if (flush) begin
            mq.delete();
        end else begin
            if (of) void'(mq.pop_front());
            if (inf) mq.push_back('{inst_addr, inst});
        end
        #1;
    endtask

    task automatic offer(input logic [31:0] a);
        in_valid  = 1'b1;
        inst_addr = a;
        inst      = a ^ 32'hA5C3_0000;
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && rst_n) begin
                chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
                chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
                chk("inst_addr", 64'(addr_o), (mq.size() > 0) ? 64'(mq[0].a) : 64'(0));
                chk("inst", 64'(inst_o), (mq.size() > 0) ? 64'(mq[0].d) : 64'(NOP));
                chk("bubble_cnt", 64'(bubble_cnt), 64'(mcnt));
            end
        end
    end

    initial begin
        chk_en    = 1'b0;
        n_total   = 0;
        n_pass    = 0;
        mcnt      = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        inst_addr = '0;
        inst      = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_inst", 64'(inst_o), 64'(32'h13));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (10) tick();
        chk("idle_bubble10", 64'(bubble_cnt), 64'(10));
        chk("idle_inst", 64'(inst_o), 64'(32'h13));
        chk("idle_addr", 64'(addr_o), 64'(0));
        chk("idle_in_ready", 64'(in_ready), 64'(1));

        // Streaming
        for (int i = 0; i < 4; i++) begin
            offer(32'h100 + 32'(4 * i));
            tick();
            chk("stream_addr", 64'(addr_o), 64'(32'h100 + 32'(4 * i)));
            chk("stream_ready", 64'(in_ready), 64'(1));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", 64'(out_valid), 64'(0));

        // Backpressure
        offer(32'h200); tick();
        offer(32'h204); tick();
        chk("bp_204", 64'(addr_o), 64'(32'h204));
        out_ready = 1'b0;
        offer(32'h208);
        tick();
        chk("bp_full_ready", 64'(in_ready), 64'(0));
        offer(32'h20C);
        repeat (2) begin
            tick();
            chk("bp_hold_addr", 64'(addr_o), 64'(32'h204));
            chk("bp_hold_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_208", 64'(addr_o), 64'(32'h208));
        chk("bp_rel_ready", 64'(in_ready), 64'(1));
        tick();
        chk("bp_20c", 64'(addr_o), 64'(32'h20C));
        offer(32'h210); tick();
        chk("bp_210", 64'(addr_o), 64'(32'h210));
        offer(32'h214); tick();
        chk("bp_214", 64'(addr_o), 64'(32'h214));
        in_valid = 1'b0;
        tick();

        // Flush while full, with an instruction offered on the flush cycle
        out_ready = 1'b0;
        offer(32'h300); tick();
        offer(32'h304); tick();
        chk("fl_full_addr", 64'(addr_o), 64'(32'h300));
        chk("fl_full_ready", 64'(in_ready), 64'(0));
        offer(32'h308);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'(0));
        chk("fl_inst", 64'(inst_o), 64'(32'h13));
        chk("fl_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("fl_no_308", 64'(out_valid), 64'(0));
        end

        // Asynchronous reset while full
        out_ready = 1'b0;
        offer(32'h400); tick();
        offer(32'h404); tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'(0));
        chk("arst_inst", 64'(inst_o), 64'(32'h13));
        chk("arst_addr", 64'(addr_o), 64'(0));
        chk("arst_ready", 64'(in_ready), 64'(1));
        chk("arst_cnt", 64'(bubble_cnt), 64'(0));
        mq.delete();
        mcnt = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        offer(32'h500);
        tick();
        in_valid = 1'b0;
        chk("arst_first_valid", 64'(out_valid), 64'(1));
        chk("arst_first_addr", 64'(addr_o), 64'(32'h500));
        tick();

        // Counter saturation and clear priority
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        repeat (20) tick();
        chk("cnt_sat", 64'(bubble_cnt), 64'(15));
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr", 64'(bubble_cnt), 64'(0));

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 65);
            inst_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            inst      = $urandom;
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 29) == 0);
            cnt_clr   = ($urandom_range(0, 49) == 0);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        cnt_clr  = 1'b0;
        tick();
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_id_skid.md
# if_id_skid

Parametrised fetch/decode pipeline register carrying the instruction address and word from IF to ID, replacing fixed stall-vector control with a valid/ready handshake. A two-entry skid buffer gives full throughput with a fully registered `in_ready_o`, so there is no combinational path from `out_ready_i` back to fetch. Flush inserts clean NOP bubbles. A saturating counter records ID-starvation cycles for performance analysis.

## Interface
- `ADDR_WIDTH`, 32: instruction address width.
- `DATA_WIDTH`, 32: instruction word width.
- `NOP_INST`, 32'h00000013: word driven on `inst_o` whenever `out_valid_o`=0.
- `CNT_WIDTH`, 16: bubble counter width.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset; one clock, reset asynchronous and active-low.
- `flush_i` in 1: discard all held entries (branch/exception redirect).
- `in_valid_i` in 1: IF presents an instruction.
- `in_ready_o` out 1: stage can accept; registered.
- `inst_addr_i` in ADDR_WIDTH: IF instruction address.
- `inst_i` in DATA_WIDTH: IF instruction word.
- `out_valid_o` out 1: ID-side instruction valid.
- `out_ready_i` in 1: ID accepts this cycle.
- `inst_addr_o` out ADDR_WIDTH: held address; 0 when invalid.
- `inst_o` out DATA_WIDTH: held instruction; `NOP_INST` when invalid.
- `cnt_clr_i` in 1: synchronous clear of bubble counter.
- `bubble_cnt_o` out CNT_WIDTH: saturating count of starvation cycles.

## Operation
- Handshake events:
  - in_fire = `in_valid_i` & `in_ready_o`.
  - out_fire = `out_valid_o` & `out_ready_i`.
- Storage is a main entry, which drives the outputs, plus a skid entry.
- States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
  - `out_valid_o` = (state != EMPTY).
  - `in_ready_o` = (state != FULL), produced from a register.
- EMPTY transitions:
  - in_fire: main <= input, go to ONE.
  - otherwise: stay EMPTY.
- ONE transitions:
  - in_fire & out_fire: main <= input, stay ONE.
  - in_fire & !out_fire: skid <= input, go to FULL.
  - !in_fire & out_fire: go to EMPTY.
  - otherwise: hold.
- FULL transitions (no in_fire possible):
  - out_fire: main <= skid, go to ONE.
  - otherwise: hold both entries.
- Order is strictly preserved; no entry is ever dropped or duplicated except by flush.
- Invalid outputs:
  - `inst_o` = `NOP_INST`.
  - `inst_addr_o` = 0.
  - These values are clean register values, not don't-care.
- Flush:
  - `flush_i`=1 at an edge forces EMPTY and `in_ready_o`=1, overriding all transitions.
  - An instruction offered on the flush cycle is discarded even if `in_ready_o` was 1.
  - A simultaneous out_fire still counts as consumed by ID; ID qualifies with its own flush.
- Bubble counter:
  - Increments by 1 at an edge when `out_ready_i`=1 & `out_valid_o`=0 & `flush_i`=0.
  - Saturates at all-ones.
  - `cnt_clr_i` sets it to 0 and has priority over increment.

## Timing
- Reset (asynchronous, `rst_ni`=0), output values:
  - `out_valid_o`=0, `inst_o`=`NOP_INST`, `inst_addr_o`=0.
  - `in_ready_o`=1, `bubble_cnt_o`=0, state EMPTY.
- Reset asserted mid-operation discards both entries immediately, without waiting for a clock edge.
- The first in_fire is possible at the first rising edge after `rst_ni` deasserts.
- Latency: data accepted at edge N is visible on the outputs right after edge N, so ID samples it at edge N+1.
- Throughput: 1 instruction/cycle sustained while `out_ready_i`=1.
- Backpressure: when `out_ready_i` drops, at most one more instruction is accepted (into skid). `in_ready_o` falls the edge after.
- When out_fire occurs in FULL, `in_ready_o` returns to 1 one cycle later.
- Outputs are stable whenever `out_valid_o`=1 & `out_ready_i`=0.
- Inputs may change freely when `in_ready_o`=0.

## Test plan
- Reset/idle: hold `rst_ni`=0, then release with `in_valid_i`=0 and `out_ready_i`=1 for 10 cycles.
  - Outputs: `out_valid_o`=0, `inst_o`=32'h00000013, `inst_addr_o`=0, `in_ready_o`=1.
  - `bubble_cnt_o`=10.
- Streaming: feed addresses 0x100, 0x104, 0x108, 0x10C back-to-back with `out_ready_i`=1.
  - The same four appear on consecutive cycles, each one cycle after acceptance.
  - `in_ready_o` stays 1.
- Backpressure: stream 0x200..0x214 and drop `out_ready_i` for 3 cycles after 0x204 is on the outputs.
  - 0x208 enters skid; `in_ready_o`=0 for the stall.
  - On release, the output sequence is 0x204, 0x208, 0x20C… with no loss or duplicate.
- Flush in FULL: fill main=0x300 and skid=0x304, then pulse `flush_i` together with `in_valid_i` for 0x308.
  - Next cycle: `out_valid_o`=0, `inst_o`=NOP, `in_ready_o`=1.
  - 0x308 never appears.
- Async reset mid-stream: assert `rst_ni`=0 between edges while FULL.
  - Outputs return to their reset values immediately.
  - After release, the first accepted instruction is delivered normally.
- Counter: with `CNT_WIDTH`=4, starve for 20 cycles.
  - `bubble_cnt_o`=15 (saturated).
  - Assert `cnt_clr_i` together with a starvation cycle: next value 0.
